// File: rtl/imem_boot_pkg.sv
// imem_boot_pkg
// Shared definitions for the instruction-memory boot sequencer:
//   - state_e   : sequencer state encoding
//   - LANES     : bytes per program word
//   - CYCLE_W   : width of the run-cycle counter
//   - lane_byte : selects byte lane k (little-endian) from a 32-bit word
package imem_boot_pkg;

  localparam int LANES   = 4;
  localparam int CYCLE_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_LOAD_WAIT = 3'd2,
    ST_WRITE     = 3'd3,
    ST_RELEASE   = 3'd4,
    ST_RUN       = 3'd5,
    ST_DONE      = 3'd6
  } state_e;

  // Lane 0 is the least significant byte, so memory ends up little-endian.
  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl
// Boot and run sequencer in front of the pipelined core. Holds the core in
// reset, zero-fills instruction memory, streams 32-bit program words into it
// byte by byte (little-endian), then releases the core and stops it on a
// cycle budget or an external halt.
// Ports:
//   clk, reset (async, active-low)
//   start                        : begin clear+load (IDLE/DONE only)
//   ld_valid/ld_ready/ld_word/ld_last : program word stream
//   halt_req                     : stop request, honoured in RUN
//   imem_we/imem_addr/imem_wdata : byte write port to instruction memory
//   cpu_reset, cpu_stall         : core control
//   busy, done, err, cycle_count : status
// All outputs come straight from flops; output registers are loaded from the
// next-state values so they line up with the state register.
module imem_boot_ctrl
  import imem_boot_pkg::*;
#(
  parameter int IMEM_BYTES = 256,
  parameter int ADDR_W     = 8,
  parameter int RUN_CYCLES = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [31:0]        ld_word,
  input  logic               ld_last,
  input  logic               halt_req,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [7:0]         imem_wdata,
  output logic               cpu_reset,
  output logic               cpu_stall,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CYCLE_W-1:0] cycle_count
);

  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(IMEM_BYTES - 1);
  localparam logic [CYCLE_W-1:0] RUN_LIMIT = CYCLE_W'(RUN_CYCLES);

  state_e               state_r, state_nxt_s;
  logic [ADDR_W-1:0]    ptr_r, ptr_nxt_s;     // shared by CLEAR and WRITE
  logic [1:0]           lane_r, lane_nxt_s;
  logic [31:0]          word_r, word_nxt_s;
  logic                 last_r, last_nxt_s;
  logic                 err_r, err_nxt_s;
  logic [CYCLE_W-1:0]   cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [ADDR_W-1:0]    ptr_step_s;

  logic                 we_r, we_nxt_s;
  logic [ADDR_W-1:0]    addr_r, addr_nxt_s;
  logic [7:0]           wdata_r, wdata_nxt_s;
  logic                 ready_r, cpu_reset_r, cpu_stall_r, busy_r, done_r;

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    lane_nxt_s  = lane_r;
    word_nxt_s  = word_r;
    last_nxt_s  = last_r;
    err_nxt_s   = err_r;
    cnt_nxt_s   = cnt_r;
    ptr_step_s  = ptr_r + ADDR_W'(4);
    // Counter saturates rather than wrapping.
    cnt_inc_s   = (&cnt_r) ? cnt_r : cnt_r + CYCLE_W'(1);

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt_s = ST_CLEAR;
          ptr_nxt_s   = '0;
          err_nxt_s   = 1'b0;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_CLEAR: begin
        if (ptr_r == LAST_ADDR) begin
          state_nxt_s = ST_LOAD_WAIT;
          ptr_nxt_s   = '0;
        end else begin
          ptr_nxt_s   = ptr_r + ADDR_W'(1);
        end
      end
      ST_LOAD_WAIT: begin
        if (ld_valid) begin
          state_nxt_s = ST_WRITE;
          word_nxt_s  = ld_word;
          last_nxt_s  = ld_last;
          lane_nxt_s  = 2'd0;
        end else begin
          state_nxt_s = ST_LOAD_WAIT;
        end
      end
      ST_WRITE: begin
        lane_nxt_s = lane_r + 2'd1;
        if (lane_r == 2'd3) begin
          ptr_nxt_s = ptr_step_s;
          if (last_r) begin
            state_nxt_s = ST_RELEASE;
          end else if (ptr_step_s == '0) begin
            // Memory filled without a last marker.
            err_nxt_s   = 1'b1;
            state_nxt_s = ST_RELEASE;
          end else begin
            state_nxt_s = ST_LOAD_WAIT;
          end
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end
      ST_RELEASE: begin
        state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        cnt_nxt_s = cnt_inc_s;
        if (halt_req || ((RUN_LIMIT != '0) && (cnt_inc_s == RUN_LIMIT))) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    we_nxt_s = (state_nxt_s == ST_CLEAR) || (state_nxt_s == ST_WRITE);
    if (state_nxt_s == ST_CLEAR) begin
      addr_nxt_s  = ptr_nxt_s;
      wdata_nxt_s = 8'h00;
    end else if (state_nxt_s == ST_WRITE) begin
      addr_nxt_s  = ptr_nxt_s + ADDR_W'(lane_nxt_s);
      wdata_nxt_s = lane_byte(word_nxt_s, lane_nxt_s);
    end else begin
      addr_nxt_s  = '0;
      wdata_nxt_s = 8'h00;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
      lane_r  <= 2'd0;
      word_r  <= 32'h0000_0000;
      last_r  <= 1'b0;
      err_r   <= 1'b0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      lane_r  <= lane_nxt_s;
      word_r  <= word_nxt_s;
      last_r  <= last_nxt_s;
      err_r   <= err_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Output registers, loaded from the next state so they track state_r.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_r        <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= 8'h00;
      ready_r     <= 1'b0;
      cpu_reset_r <= 1'b1;
      cpu_stall_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      we_r        <= we_nxt_s;
      addr_r      <= addr_nxt_s;
      wdata_r     <= wdata_nxt_s;
      ready_r     <= (state_nxt_s == ST_LOAD_WAIT);
      cpu_reset_r <= (state_nxt_s != ST_RUN) && (state_nxt_s != ST_DONE);
      cpu_stall_r <= (state_nxt_s == ST_DONE);
      busy_r      <= (state_nxt_s == ST_CLEAR) || (state_nxt_s == ST_LOAD_WAIT) ||
                     (state_nxt_s == ST_WRITE) || (state_nxt_s == ST_RELEASE);
      done_r      <= (state_nxt_s == ST_DONE);
    end
  end

  assign imem_we     = we_r;
  assign imem_addr   = addr_r;
  assign imem_wdata  = wdata_r;
  assign ld_ready    = ready_r;
  assign cpu_reset   = cpu_reset_r;
  assign cpu_stall   = cpu_stall_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign err         = err_r;
  assign cycle_count = cnt_r;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
module tb_imem_boot_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, ld_valid, ld_last, halt_req;
  logic [31:0] ld_word;
  logic        ld_ready, imem_we, cpu_reset, cpu_stall, busy, done, err;
  logic [7:0]  imem_addr, imem_wdata;
  logic [31:0] cycle_count;

  imem_boot_ctrl #(.IMEM_BYTES(256), .ADDR_W(8), .RUN_CYCLES(35)) dut (
    .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_word(ld_word), .ld_last(ld_last),
    .halt_req(halt_req), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .cpu_stall(cpu_stall),
    .busy(busy), .done(done), .err(err), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic        last;
    logic [7:0]  b0, b1, b2, b3;
  } vec_t;

  vec_t prog[11];
  logic [7:0] mem[256];
  logic [7:0] golden[256];
  logic       prefill;
  int         passed = 0;
  int         total  = 0;
  int         cyc = 0, last_we_cyc = 0, fall_cyc = 0, viol = 0;
  logic       prev_cpu_reset = 1'b1;

  // Instruction memory model.
  always @(posedge clk) begin
    if (prefill) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'hAA;
    end else if (imem_we) begin
      mem[imem_addr] <= imem_wdata;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Observes write/release timing and ld_ready during writes.
  always @(negedge clk) begin
    if (imem_we) last_we_cyc <= cyc;
    if (prev_cpu_reset && !cpu_reset) fall_cyc <= cyc;
    prev_cpu_reset <= cpu_reset;
    if (imem_we && ld_ready) viol <= viol + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ld_ready && n < 1000) begin tick(); n++; end
    chk("ld_ready_seen", {31'd0, ld_ready}, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input logic l, input int gap);
    int   n = 0;
    logic hs = 1'b0;
    repeat (gap) tick();
    ld_word  = w;
    ld_last  = l;
    ld_valid = 1'b1;
    while (!hs && n < 200) begin hs = ld_ready; tick(); n++; end
    ld_valid = 1'b0;
    chk("handshake", {31'd0, hs}, 32'd1);
  endtask

  task automatic wait_run();
    int n = 0;
    while (cpu_reset && n < 2000) begin tick(); n++; end
    chk("core_released", {31'd0, cpu_reset}, 32'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 2000) begin tick(); n++; end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic load_prog(input logic rand_gaps);
    for (int i = 0; i < 11; i++)
      send_word(prog[i].word, prog[i].last, rand_gaps ? int'($urandom_range(0, 7)) : 0);
  endtask

  task automatic cmp_golden(input string name);
    int d = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== golden[i]) d++;
    chk(name, d, 0);
  endtask

  initial begin
    int z;
    int bad;
    prog[0]  = '{32'h2008_0001, 1'b0, 8'h01, 8'h00, 8'h08, 8'h20};
    prog[1]  = '{32'h2009_0002, 1'b0, 8'h02, 8'h00, 8'h09, 8'h20};
    for (int i = 2; i < 8; i++) prog[i] = '{32'h0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
    prog[8]  = '{32'h1109_0001, 1'b0, 8'h01, 8'h00, 8'h09, 8'h11};
    prog[9]  = '{32'h200A_0063, 1'b0, 8'h63, 8'h00, 8'h0A, 8'h20};
    prog[10] = '{32'h200A_0005, 1'b1, 8'h05, 8'h00, 8'h0A, 8'h20};

    reset = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_word = 32'h0;
    ld_last = 1'b0; halt_req = 1'b0; prefill = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
    chk("rst_imem_addr", {24'd0, imem_addr}, 32'd0);
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_count", cycle_count, 32'd0);
    prefill = 1'b0;
    reset   = 1'b1;
    tick();

    // Back-to-back program load and budgeted run.
    do_start();
    chk("start_first_we", {31'd0, imem_we}, 32'd1);
    chk("start_first_addr", {24'd0, imem_addr}, 32'd0);
    chk("start_busy", {31'd0, busy}, 32'd1);
    z = 0;
    while (!ld_ready && z < 1000) begin tick(); z++; end
    chk("clear_cycles", z, 256);
    load_prog(1'b0);
    wait_done();
    chk("release_latency", fall_cyc - last_we_cyc, 2);
    chk("budget_count", cycle_count, 32'd35);
    chk("done_stall", {31'd0, cpu_stall}, 32'd1);
    chk("done_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    chk("done_busy", {31'd0, busy}, 32'd0);
    chk("done_err", {31'd0, err}, 32'd0);
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("img_w%0d", i), {mem[4*i+3], mem[4*i+2], mem[4*i+1], mem[4*i]},
          {prog[i].b3, prog[i].b2, prog[i].b1, prog[i].b0});
    end
    z = 0;
    for (int i = 44; i < 256; i++) if (mem[i] !== 8'h00) z++;
    chk("tail_cleared", z, 0);
    for (int i = 0; i < 256; i++) golden[i] = mem[i];

    // Restart from DONE, gappy load, start ignored in RUN, halt at cycle 10.
    do_start();
    chk("restart_busy", {31'd0, busy}, 32'd1);
    chk("restart_count", cycle_count, 32'd0);
    chk("restart_done", {31'd0, done}, 32'd0);
    wait_ready();
    load_prog(1'b1);
    wait_run();
    chk("run_count0", cycle_count, 32'd0);
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_run_count", cycle_count, 32'd4);
    chk("start_in_run_busy", {31'd0, busy}, 32'd0);
    chk("start_in_run_rst", {31'd0, cpu_reset}, 32'd0);
    repeat (5) tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("halt_count", cycle_count, 32'd10);
    chk("halt_done", {31'd0, done}, 32'd1);
    chk("halt_stall", {31'd0, cpu_stall}, 32'd1);
    tick();
    chk("halt_hold", cycle_count, 32'd10);
    cmp_golden("gappy_image");
    chk("ready_during_write", viol, 0);

    // Overflow: 64 words without a last marker; halt ignored during clear.
    do_start();
    halt_req = 1'b1;
    repeat (5) tick();
    halt_req = 1'b0;
    chk("halt_ignored_busy", {31'd0, busy}, 32'd1);
    chk("halt_ignored_done", {31'd0, done}, 32'd0);
    wait_ready();
    for (int i = 0; i < 64; i++) begin
      logic [7:0] a;
      a = 8'(4 * i);
      send_word({a + 8'd3, a + 8'd2, a + 8'd1, a}, 1'b0, 0);
    end
    wait_run();
    chk("ovf_err", {31'd0, err}, 32'd1);
    chk("ovf_word63", {mem[255], mem[254], mem[253], mem[252]}, 32'hFFFE_FDFC);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== 8'(i)) bad++;
    chk("ovf_image", bad, 0);
    wait_done();
    chk("ovf_count", cycle_count, 32'd35);
    chk("ovf_err_sticky", {31'd0, err}, 32'd1);
    do_start();
    chk("start_clears_err", {31'd0, err}, 32'd0);
    chk("start_clears_count", cycle_count, 32'd0);

    // Reset during lane 2 of word 3, then a clean reload.
    wait_ready();
    send_word(prog[0].word, 1'b0, 0);
    send_word(prog[1].word, 1'b0, 0);
    send_word(32'hA1B2_C3D4, 1'b0, 0);
    tick();
    tick();
    chk("lane2_addr", {24'd0, imem_addr}, 32'd10);
    chk("lane2_data", {24'd0, imem_wdata}, 32'h0000_00B2);
    reset = 1'b0;
    #1;
    chk("midrst_we", {31'd0, imem_we}, 32'd0);
    chk("midrst_addr", {24'd0, imem_addr}, 32'd0);
    chk("midrst_data", {24'd0, imem_wdata}, 32'd0);
    chk("midrst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, ld_ready}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    do_start();
    wait_ready();
    load_prog(1'b0);
    wait_done();
    cmp_golden("reload_image");
    chk("reload_count", cycle_count, 32'd35);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
